// File: rtl/fifo_rd_stream_bridge.sv
// fifo_rd_stream_bridge
//   Read-side drain stage for the synchronous FIFO. It turns the FIFO read
//   interface (fifo_r_en / fifo_empty, data one cycle after the read) into a
//   valid/ready stream at full throughput. A 2-entry registered skid buffer
//   plus in-flight read tracking makes sure back-pressure never drops or
//   duplicates a word.
//
// Build option:
//   BRIDGE_LAST_EN - adds the m_last port and a beat counter that flags every
//                    BURST_LEN-th beat. Without it, BURST_LEN is unused.
//
// Ports:
//   clk            single clock domain
//   rst            asynchronous active-high reset
//   flush          synchronous drop of buffered and in-flight data
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after an accepted read
//   fifo_r_en      FIFO read enable (combinational)
//   m_valid        stream data valid
//   m_ready        stream consumer ready
//   m_data         stream data (registered)
//   m_last         end of burst (BRIDGE_LAST_EN only)
//   busy           buffered data present or a read in flight

module fifo_rd_stream_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef BRIDGE_LAST_EN
  output logic                  m_last,
`endif
  output logic                  busy
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_rd_stream_bridge: BURST_LEN must be at least 1");
  end

  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;

  logic                  pop;
  logic                  capture;
  logic [1:0]            outstanding;
  logic                  head_nxt;
  logic [2:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] head_word_nxt;

  assign pop         = m_valid & m_ready;
  assign capture     = inflight_q;
  assign outstanding = occ_q + {1'b0, inflight_q};

  // A read is allowed when the returning word is guaranteed a slot: either
  // fewer than two words are owed to the buffer, or one leaves this cycle.
  assign fifo_r_en = !rst && !fifo_empty && !flush &&
                     ((outstanding < 2'd2) || ((outstanding == 2'd2) && pop));

  assign head_nxt = head_q ^ pop;
  assign occ_nxt  = {1'b0, occ_q} + {2'b00, capture} - {2'b00, pop};

  // m_data is a register, so the word to present next cycle is chosen here.
  // When the buffer drains to the slot being written this edge, the incoming
  // word is forwarded into the output register alongside the buffer write.
  always_comb begin
    head_word_nxt = skid_q[head_nxt];
    if (capture && (tail_q == head_nxt)) begin
      head_word_nxt = fifo_data_out;
    end
  end

  assign m_valid = (occ_q != 2'd0);
  assign busy    = (occ_q != 2'd0) || inflight_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      m_data     <= '0;
    end else if (flush) begin
      // The word landing this edge from an earlier read is discarded.
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_r_en;
      if (capture) begin
        skid_q[tail_q] <= fifo_data_out;
      end
      tail_q <= tail_q ^ capture;
      head_q <= head_nxt;
      occ_q  <= occ_nxt[1:0];
      m_data <= head_word_nxt;
    end
  end

  // The in-flight accounting must keep occupancy within the two entries.
  occ_bound_a : assert property (
    @(posedge clk) disable iff (rst) !flush |-> (occ_nxt <= 3'd2)
  );

`ifdef BRIDGE_LAST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] beat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (flush) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= (beat_cnt_q == CNT_LAST) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  assign m_last = m_valid && (beat_cnt_q == CNT_LAST);
`endif

endmodule
